serial_sub_seq: RTL



---
 rtl/serial_sub_if.sv | 33 +++
 rtl/serial_sub_seq.sv | 113 +++++++++++
 2 files changed

// File: rtl/serial_sub_if.sv
// serial_sub_if: start/done handshake and operand/result bus of serial_sub_seq.
// ovf exists only when SERIAL_SUB_SIGNED_EN is defined.
interface serial_sub_if #(
    parameter int WIDTH = 8
) ();
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             bout;
`ifdef SERIAL_SUB_SIGNED_EN
    logic             ovf;
`endif

    modport master (
        output start, a, b, bin,
        input  busy, done, d, bout
`ifdef SERIAL_SUB_SIGNED_EN
        , ovf
`endif
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, d, bout
`ifdef SERIAL_SUB_SIGNED_EN
        , ovf
`endif
    );
endinterface

// File: rtl/serial_sub_seq.sv
// serial_sub_seq: bit-serial {bout, d} = a - b - bin, LSB first, one bit per clock.
// Define SERIAL_SUB_SIGNED_EN to add the registered signed-overflow flag ovf.
module serial_sub_seq #(
    parameter int WIDTH = 8
) (
    input logic         clk,
    input logic         rst_n,
    serial_sub_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, d_q, d_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d, bout_q, bout_d;
    logic             accept, last, di, br_nxt;
    logic [WIDTH:0]   d_sh;

    // DONE accepts a new start exactly like IDLE, giving back-to-back issue
    assign accept = (state_q != RUN) && bus.start;
    assign last   = cnt_q == CW'(WIDTH - 1);
    assign di     = a_q[0] ^ b_q[0] ^ br_q;
    assign br_nxt = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    assign d_sh   = {di, d_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = (state_q == RUN) ? (last ? DONE : RUN) : (bus.start ? RUN : IDLE);
    end

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        br_d   = br_q;
        cnt_d  = cnt_q;
        d_d    = d_q;
        bout_d = bout_q;
        if (accept) begin
            a_d   = bus.a;
            b_d   = bus.b;
            br_d  = bus.bin;
            cnt_d = '0;
        end else if (state_q == RUN) begin
            a_d    = a_q >> 1;
            b_d    = b_q >> 1;
            br_d   = br_nxt;
            cnt_d  = cnt_q + 1'b1;
            d_d    = d_sh[WIDTH:1];
            bout_d = br_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            br_q   <= 1'b0;
            cnt_q  <= '0;
            d_q    <= '0;
            bout_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            br_q   <= br_d;
            cnt_q  <= cnt_d;
            d_q    <= d_d;
            bout_q <= bout_d;
        end
    end

`ifdef SERIAL_SUB_SIGNED_EN
    logic sa_q, sa_d, sb_q, sb_d, ovf_q, ovf_d;

    // di on the last RUN cycle is the result sign bit
    always_comb begin
        sa_d  = accept ? bus.a[WIDTH-1] : sa_q;
        sb_d  = accept ? bus.b[WIDTH-1] : sb_q;
        ovf_d = (state_q == RUN && last) ? ((sa_q != sb_q) && (di != sa_q)) : ovf_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa_q  <= 1'b0;
            sb_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            sa_q  <= sa_d;
            sb_q  <= sb_d;
            ovf_q <= ovf_d;
        end
    end

    always_comb begin
        bus.ovf = ovf_q;
    end
`endif

    always_comb begin
        bus.busy = state_q == RUN;
        bus.done = state_q == DONE;
        bus.d    = d_q;
        bus.bout = bout_q;
    end
endmodule
